// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Brief    : Runtime-loadable serial pattern detector with a registered match
//             pulse, a saturating match counter and a sticky config error flag.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'h0D,
    parameter int                 RST_LEN     = 5,
    parameter bit                 RST_OVERLAP = 1'b1,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [MAX_LEN-1:0] r_hist;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_match;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_cfg_ok;
    logic               w_hit;

    always_comb begin
        w_hist_n = {r_hist[MAX_LEN-2:0], in_bit};
        w_fill_n = (r_fill >= c_MAX_LEN) ? c_MAX_LEN : r_fill + 1'b1;
        // Only the low r_len history bits take part in the comparison.
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < r_len) begin
                w_mask[i] = 1'b1;
            end
        end
        w_cfg_ok = (cfg_len != '0) && (cfg_len <= c_MAX_LEN);
        w_hit    = in_valid && !cfg_load && (w_fill_n >= r_len) &&
                   (((w_hist_n ^ r_pat) & w_mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= RST_PATTERN;
            r_len   <= LEN_W'(RST_LEN);
            r_ovl   <= RST_OVERLAP;
            r_match <= 1'b0;
            r_err   <= 1'b0;
        end else if (cfg_load) begin
            r_match <= 1'b0;
            if (w_cfg_ok) begin
                r_pat  <= cfg_pattern;
                r_len  <= cfg_len;
                r_ovl  <= cfg_overlap;
                r_err  <= 1'b0;
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_err <= 1'b1;
            end
        end else if (in_valid) begin
            r_match <= w_hit;
            r_hist  <= w_hist_n;
            // Non-overlapping mode demands a full fresh pattern after each hit.
            r_fill  <= (w_hit && !r_ovl) ? '0 : w_fill_n;
        end else begin
            r_match <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match       = r_match;
    assign match_count = r_cnt;
    assign cfg_err     = r_err;

endmodule
`default_nettype wire
